nibble_serial_adder: RTL and testbench

- Bit-slice-serial word adder built around a 4-bit add slice: x + y + carry.
- Accepts one operand nibble pair per handshake, least-significant nibble first.
- Chains carry across NIBBLES slices and assembles the full-width sum.
- Presents the result on a valid/ready output port. Sits between the operand sequencer (upstream) and the result consumer (downstream).

---
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit words (W = 4*NIBBLES) one nibble pair at a time, least
//   significant nibble first. The carry is chained across slices. When the
//   word is complete, the sum is held on a valid/ready output port.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     abort                 synchronous clear of partial or held word
//     in_valid / in_ready   operand nibble handshake (x_nib, y_nib, cin)
//     cin                   word carry-in, used only on the first nibble
//     out_valid / out_ready result handshake (sum, cout, ovf)
//     busy                  word in progress or result held
//
//   state | meaning
//   ------+---------------------------------------------------------
//   ACCUM | accepting nibble pairs, in_ready=1
//   HOLD  | full word assembled, out_valid=1 until the consumer takes it
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           x_nib,
    input  logic [3:0]           y_nib,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   nib_cnt;
    logic            carry;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            ovf_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic            slice_cin;
    logic [3:0]      slice_lo;    // low 3 bits plus their carry into bit 3
    logic [4:0]      slice_sum;
    logic            last_nib;

    always_comb begin
        slice_cin = (nib_cnt == '0) ? cin : carry;
        slice_lo  = {1'b0, x_nib[2:0]} + {1'b0, y_nib[2:0]} + {3'b000, slice_cin};
        slice_sum = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, slice_cin};
        last_nib  = (nib_cnt == CW'(NIBBLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            nib_cnt     <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state       <= ACCUM;
            nib_cnt     <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        sum_q[{nib_cnt, 2'b00} +: 4] <= slice_sum[3:0];
                        carry <= slice_sum[4];
                        if (last_nib) begin
                            cout_q      <= slice_sum[4];
                            // overflow: carry into the sign bit differs from carry out
                            ovf_q       <= slice_lo[3] ^ slice_sum[4];
                            nib_cnt     <= '0;
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            nib_cnt <= nib_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state       <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = (nib_cnt != '0) | out_valid_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4 (16-bit words).
// Inputs are driven and outputs are sampled on the falling edge.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  x_nib;
    logic [3:0]  y_nib;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_nib     (x_nib),
        .y_nib     (y_nib),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Offers nibbles 0..n-1 of x/y back to back; returns at the falling edge
    // after the last offered nibble with in_valid low. With tog set, cin is
    // inverted on every nibble after the first.
    task automatic send_nibs(input logic [15:0] x, input logic [15:0] y,
                             input logic c, input logic tog, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("in_ready_before_nib", in_ready, 1'b1);
            if (i == 3) check("no_early_valid", out_valid, 1'b0);
            in_valid = 1'b1;
            x_nib    = x[4*i +: 4];
            y_nib    = y[4*i +: 4];
            cin      = (i != 0 && tog) ? ~c : c;
        end
        @(negedge clk);
        in_valid = 1'b0;
        cin      = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] s,
                                input logic co, input logic ov);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_sum"}, sum, s);
        check({tag, "_cout"}, cout, co);
        check({tag, "_ovf"}, ovf, ov);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        x_nib     = 4'h0;
        y_nib     = 4'h0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);

        // basic add
        send_nibs(16'h1234, 16'h4321, 1'b0, 1'b0, 4);
        check_result("t1", 16'h5555, 1'b0, 1'b0);
        consume("t1");

        // carry chain out of the word
        send_nibs(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4);
        check_result("t2a", 16'h0000, 1'b1, 1'b0);
        consume("t2a");

        // cin only used on the first nibble
        send_nibs(16'h0000, 16'h0000, 1'b1, 1'b1, 4);
        check_result("t2b", 16'h0001, 1'b0, 1'b0);
        consume("t2b");

        // signed overflow cases
        send_nibs(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4);
        check_result("t3a", 16'h8000, 1'b0, 1'b1);
        consume("t3a");
        send_nibs(16'h8000, 16'h8000, 1'b0, 1'b0, 4);
        check_result("t3b", 16'h0000, 1'b1, 1'b1);
        consume("t3b");

        // backpressure: junk offered while the result is held
        send_nibs(16'h1234, 16'h1111, 1'b0, 1'b0, 4);
        check_result("t4_hold", 16'h2345, 1'b0, 1'b0);
        in_valid = 1'b1;
        x_nib    = 4'hF;
        y_nib    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_result("t4_bp", 16'h2345, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        consume("t4");
        send_nibs(16'h0F0F, 16'h0101, 1'b0, 1'b0, 4);
        check_result("t4_next", 16'h1010, 1'b0, 1'b0);
        consume("t4_next");

        // abort mid-word; the nibble offered with abort is discarded
        send_nibs(16'h3333, 16'h3333, 1'b0, 1'b0, 2);
        check("t5_busy_mid", busy, 1'b1);
        abort    = 1'b1;
        in_valid = 1'b1;
        x_nib    = 4'h7;
        y_nib    = 4'h7;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t5_busy_after_abort", busy, 1'b0);
        check("t5_sum_cleared", sum, 16'h0000);
        check("t5_in_ready", in_ready, 1'b1);
        send_nibs(16'h00FF, 16'h0F01, 1'b0, 1'b0, 4);
        check_result("t5_fresh", 16'h1000, 1'b0, 1'b0);

        // abort while holding, even with out_ready high
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check("t5h_valid", out_valid, 1'b0);
        check("t5h_sum", sum, 16'h0000);
        check("t5h_busy", busy, 1'b0);
        check("t5h_in_ready", in_ready, 1'b1);

        // async reset mid-word, between clock edges
        send_nibs(16'h2222, 16'h1111, 1'b0, 1'b0, 3);
        check("t6_sum_partial", sum, 16'h0333);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sum", sum, 16'h0000);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send_nibs(16'hAAAA, 16'h5555, 1'b0, 1'b0, 4);
        check_result("t6_after", 16'hFFFF, 1'b0, 1'b0);

        // async reset while a result is held
        #2;
        rst_n = 1'b0;
        #1;
        check("t6h_valid", out_valid, 1'b0);
        check("t6h_busy", busy, 1'b0);
        check("t6h_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
